mem_stage: RTL and testbench

//  Memory stage, directly downstream of the execute stage. Holds the EX/MEM pipeline register and performs

---
 rtl/mem_stage_pkg.sv | 28 ++
 rtl/mem_stage_aligner.sv | 46 ++++
 rtl/mem_stage.sv | 137 +++++++++++++
 tb/tb_mem_stage.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: access-size codes, FSM states and
// the EX/MEM pipeline register layout.
package mem_stage_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      REQ  = 2'b01,
      RESP = 2'b10
   } memState_t;

   typedef struct packed {
      logic        valid;
      logic [31:0] alu;
      logic [31:0] rt;
      logic [4:0]  writeAddr;
      logic        writeReg;
      logic        readMem;
      logic        writeMem;
      logic [1:0]  size;
      logic        signExt;
   } exMem_t;

endpackage

// File: rtl/mem_stage_aligner.sv
// Combinational lane logic: byte enables, store replication, load extract and
// extend, and misalignment detection for the memory stage.
module load_store_aligner
   import mem_stage_pkg::*;
(
   input  logic [1:0]  byteOffset,
   input  logic [1:0]  accessSize,
   input  logic        signExtend,
   input  logic [31:0] storeData,
   input  logic [31:0] readData,
   output logic [3:0]  byteEnable,
   output logic [31:0] writeData,
   output logic [31:0] loadData,
   output logic        misaligned
);

   logic [7:0]  loadByte;
   logic [15:0] loadHalf;

   assign loadByte = readData[{byteOffset, 3'b000} +: 8];
   assign loadHalf = byteOffset[1] ? readData[31:16] : readData[15:0];

   always_comb begin
      byteEnable = 4'b1111;
      writeData  = storeData;
      loadData   = readData;
      misaligned = |byteOffset;
      case (accessSize)
         SIZE_BYTE: begin
            byteEnable = 4'b0001 << byteOffset;
            writeData  = {4{storeData[7:0]}};
            loadData   = {{24{signExtend & loadByte[7]}}, loadByte};
            misaligned = 1'b0;
         end
         SIZE_HALF: begin
            byteEnable = 4'b0011 << {byteOffset[1], 1'b0};
            writeData  = {2{storeData[15:0]}};
            loadData   = {{16{signExtend & loadHalf[15]}}, loadHalf};
            misaligned = byteOffset[0];
         end
         // reserved size behaves exactly like a word access
         SIZE_WORD, SIZE_RSVD: misaligned = |byteOffset;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: EX/MEM register, load/store handshake FSM and the
// registered MEM/WB outputs.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  exValid,
   input  logic [DATA_WIDTH-1:0] aluOutput,
   input  logic [DATA_WIDTH-1:0] registerRt,
   input  logic [4:0]            registerWriteAddress,
   input  logic                  shouldWriteRegister,
   input  logic                  shouldReadMemory,
   input  logic                  shouldWriteMemory,
   input  logic [1:0]            memoryAccessSize,
   input  logic                  shouldSignExtendLoad,
   output logic                  memRequest,
   output logic                  memWrite,
   output logic [ADDR_WIDTH-1:0] memAddress,
   output logic [3:0]            memByteEnable,
   output logic [DATA_WIDTH-1:0] memWriteData,
   input  logic                  memReady,
   input  logic                  memResponseValid,
   input  logic [DATA_WIDTH-1:0] memReadData,
   output logic                  memStall,
   output logic                  alignmentError,
   output logic                  wbValid,
   output logic                  wbShouldWriteRegister,
   output logic [4:0]            wbRegisterWriteAddress,
   output logic [DATA_WIDTH-1:0] wbData
);

   memState_t   state, stateNext;
   exMem_t      exm, exIn;
   logic        memOp, pendingOp, accessDone, misaligned;
   logic [3:0]  byteEnable;
   logic [31:0] writeData, loadData;

   load_store_aligner aligner (
      .byteOffset (exm.alu[1:0]),
      .accessSize (exm.size),
      .signExtend (exm.signExt),
      .storeData  (exm.rt),
      .readData   (memReadData),
      .byteEnable (byteEnable),
      .writeData  (writeData),
      .loadData   (loadData),
      .misaligned (misaligned)
   );

   always_comb begin
      exIn           = '0;
      exIn.valid     = exValid;
      exIn.alu       = aluOutput;
      exIn.rt        = registerRt;
      exIn.writeAddr = registerWriteAddress;
      exIn.writeReg  = shouldWriteRegister;
      exIn.readMem   = shouldReadMemory;
      exIn.writeMem  = shouldWriteMemory;
      exIn.size      = memoryAccessSize;
      exIn.signExt   = shouldSignExtendLoad;
   end

   assign memOp     = exm.valid & (exm.readMem | exm.writeMem);
   assign pendingOp = memOp & ~misaligned;

   always_comb begin
      stateNext  = state;
      accessDone = 1'b0;
      case (state)
         IDLE: if (pendingOp) stateNext = REQ;
         REQ:  if (memReady) begin
            stateNext  = exm.writeMem ? IDLE : RESP;
            accessDone = exm.writeMem;
         end
         RESP: if (memResponseValid) begin
            stateNext  = IDLE;
            accessDone = 1'b1;
         end
         default: stateNext = IDLE;
      endcase
   end

   assign memStall       = (state == REQ) | (state == RESP) | ((state == IDLE) & pendingOp);
   assign alignmentError = (state == IDLE) & memOp & misaligned;

   // payload comes straight from EX/MEM, so it is stable for the whole REQ phase
   assign memRequest    = (state == REQ);
   assign memWrite      = memRequest & exm.writeMem;
   assign memAddress    = memRequest ? {exm.alu[ADDR_WIDTH-1:2], 2'b00} : '0;
   assign memByteEnable = memRequest ? byteEnable : 4'b0000;
   assign memWriteData  = memRequest ? writeData : '0;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         exm   <= '0;
      end else begin
         state <= stateNext;
         if (!memStall)
            exm <= exIn;
         else if (accessDone)
            exm.valid <= 1'b0;  // retire so the held op is not re-issued from IDLE
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wbValid                <= 1'b0;
         wbShouldWriteRegister  <= 1'b0;
         wbRegisterWriteAddress <= '0;
         wbData                 <= '0;
      end else begin
         wbValid               <= 1'b0;
         wbShouldWriteRegister <= 1'b0;
         if (state == IDLE && exm.valid && !memOp) begin
            wbValid                <= 1'b1;
            wbShouldWriteRegister  <= exm.writeReg;
            wbRegisterWriteAddress <= exm.writeAddr;
            wbData                 <= exm.alu;
         end else if (state == REQ && memReady && exm.writeMem) begin
            wbValid                <= 1'b1;
            wbRegisterWriteAddress <= exm.writeAddr;
            wbData                 <= exm.alu;
         end else if (state == RESP && memResponseValid) begin
            wbValid                <= 1'b1;
            wbShouldWriteRegister  <= exm.writeReg;
            wbRegisterWriteAddress <= exm.writeAddr;
            wbData                 <= loadData;
         end
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: reference model pushes expected requests and
// write-backs at capture, a memory model and a monitor check them as they occur.
module tb_mem_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        exValid;
   logic [31:0] aluOutput, registerRt;
   logic [4:0]  registerWriteAddress;
   logic        shouldWriteRegister, shouldReadMemory, shouldWriteMemory;
   logic [1:0]  memoryAccessSize;
   logic        shouldSignExtendLoad;
   logic        memRequest, memWrite;
   logic [31:0] memAddress;
   logic [3:0]  memByteEnable;
   logic [31:0] memWriteData;
   logic        memReady, memResponseValid;
   logic [31:0] memReadData;
   logic        memStall, alignmentError;
   logic        wbValid, wbShouldWriteRegister;
   logic [4:0]  wbRegisterWriteAddress;
   logic [31:0] wbData;

   always #5 clock = ~clock;

   mem_stage #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
      .clock(clock), .reset(reset), .exValid(exValid), .aluOutput(aluOutput),
      .registerRt(registerRt), .registerWriteAddress(registerWriteAddress),
      .shouldWriteRegister(shouldWriteRegister), .shouldReadMemory(shouldReadMemory),
      .shouldWriteMemory(shouldWriteMemory), .memoryAccessSize(memoryAccessSize),
      .shouldSignExtendLoad(shouldSignExtendLoad), .memRequest(memRequest),
      .memWrite(memWrite), .memAddress(memAddress), .memByteEnable(memByteEnable),
      .memWriteData(memWriteData), .memReady(memReady), .memResponseValid(memResponseValid),
      .memReadData(memReadData), .memStall(memStall), .alignmentError(alignmentError),
      .wbValid(wbValid), .wbShouldWriteRegister(wbShouldWriteRegister),
      .wbRegisterWriteAddress(wbRegisterWriteAddress), .wbData(wbData)
   );

   typedef struct {
      logic [4:0]  wa;
      logic        wsw;
      logic [31:0] data;
      logic        chkData;
   } wbExp_t;

   typedef struct {
      logic        w;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
   } reqExp_t;

   wbExp_t      wbQ[$];
   reqExp_t     reqQ[$];
   logic [31:0] refMem[int];
   logic [31:0] dutMem[int];
   int          nAssert = 0, nFail = 0;
   int          errExp = 0, errSeen = 0;
   int          waitFix = -1, respFix = -1;
   int          lastReqCycles = 0;
   logic [3:0]  lastBe = 4'h0;

   function automatic logic [31:0] initWord(input int idx);
      logic [31:0] t;
      t = 32'(idx);
      return (t * 32'h9E3779B1) ^ 32'h00C0FFEE;
   endfunction

   function automatic logic [31:0] refRead(input int idx);
      return refMem.exists(idx) ? refMem[idx] : initWord(idx);
   endfunction

   function automatic logic [31:0] dutRead(input int idx);
      return dutMem.exists(idx) ? dutMem[idx] : initWord(idx);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nAssert++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic failNow(input string name);
      nAssert++;
      nFail++;
      $display("FAIL %s: event occurred where none was expected or bound expired", name);
   endtask

   // Reference model: derive expected traffic from the instruction alone.
   task automatic model(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                        input logic [4:0] wa, input logic wr, input logic rd, input logic wm,
                        input logic [1:0] sz, input logic sx);
      int sizeBytes, off, idx;
      logic [31:0] mask, val, wd, word;
      logic [3:0]  be;
      if (!v) return;
      if (!(rd || wm)) begin
         wbQ.push_back(wbExp_t'{wa, wr, alu, 1'b1});
         return;
      end
      sizeBytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
      off       = int'(alu[1:0]);
      if (off % sizeBytes != 0) begin
         errExp++;
         return;
      end
      idx  = int'(alu >> 2);
      mask = (sizeBytes == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sizeBytes)) - 32'h1);
      be   = 4'(((1 << sizeBytes) - 1) << off);
      if (wm) begin
         wd = (sizeBytes == 1) ? (rt & 32'hFF) * 32'h0101_0101 :
              (sizeBytes == 2) ? (rt & 32'hFFFF) * 32'h0001_0001 : rt;
         word = refRead(idx);
         refMem[idx] = (word & ~(mask << (8 * off))) | ((rt & mask) << (8 * off));
         reqQ.push_back(reqExp_t'{1'b1, alu & ~32'h3, be, wd});
         wbQ.push_back(wbExp_t'{wa, 1'b0, 32'h0, 1'b0});
      end else begin
         val = (refRead(idx) >> (8 * off)) & mask;
         if (sx && sizeBytes < 4 && val[8 * sizeBytes - 1]) val = val | ~mask;
         reqQ.push_back(reqExp_t'{1'b0, alu & ~32'h3, be, 32'h0});
         wbQ.push_back(wbExp_t'{wa, wr, val, 1'b1});
      end
   endtask

   task automatic issue(input logic v, input logic [31:0] alu, input logic [31:0] rt,
                        input logic [4:0] wa, input logic wr, input logic rd, input logic wm,
                        input logic [1:0] sz, input logic sx);
      int guard = 0;
      @(negedge clock);
      exValid = v; aluOutput = alu; registerRt = rt; registerWriteAddress = wa;
      shouldWriteRegister = wr; shouldReadMemory = rd; shouldWriteMemory = wm;
      memoryAccessSize = sz; shouldSignExtendLoad = sx;
      while (memStall && guard < 100) begin
         @(negedge clock);
         guard++;
      end
      if (memStall) begin
         failNow("issue-stall-timeout");
         return;
      end
      @(posedge clock);
      model(v, alu, rt, wa, wr, rd, wm, sz, sx);
   endtask

   task automatic waitWb(input string name);
      int g = 0;
      do begin
         @(negedge clock);
         exValid = 1'b0;
         g++;
      end while (!wbValid && g < 100);
      if (!wbValid) failNow(name);
   endtask

   task automatic drain();
      int g = 0;
      while ((wbQ.size() > 0 || reqQ.size() > 0) && g < 300) begin
         @(negedge clock);
         exValid = 1'b0;
         g++;
      end
      repeat (3) @(negedge clock);
   endtask

   task automatic checkAllZero(input string tag);
      check({tag, "-memRequest"}, memRequest, 0);
      check({tag, "-memWrite"}, memWrite, 0);
      check({tag, "-memAddress"}, memAddress, 0);
      check({tag, "-memByteEnable"}, memByteEnable, 0);
      check({tag, "-memWriteData"}, memWriteData, 0);
      check({tag, "-memStall"}, memStall, 0);
      check({tag, "-alignmentError"}, alignmentError, 0);
      check({tag, "-wbValid"}, wbValid, 0);
      check({tag, "-wbShouldWrite"}, wbShouldWriteRegister, 0);
      check({tag, "-wbAddr"}, wbRegisterWriteAddress, 0);
      check({tag, "-wbData"}, wbData, 0);
   endtask

   // Memory model: random accept wait, random response delay, payload checked every request cycle.
   initial begin
      int waitCnt = 0, respDelay = 0, reqCycles = 0, idx;
      logic respPending = 1'b0;
      logic [31:0] respData = 32'h0, word;
      reqExp_t e;
      memReady = 1'b0; memResponseValid = 1'b0; memReadData = 32'h0;
      forever begin
         @(negedge clock);
         memReady = 1'b0;
         memResponseValid = 1'b0;
         if (respPending) begin
            if (respDelay == 0) begin
               memResponseValid = 1'b1;
               memReadData = respData;
               respPending = 1'b0;
            end else respDelay--;
         end
         if (reset) reqCycles = 0;
         else if (memRequest) begin
            if (reqCycles == 0) waitCnt = (waitFix >= 0) ? waitFix : int'($urandom_range(0, 2));
            reqCycles++;
            check("memStall-during-request", memStall, 1);
            if (reqQ.size() == 0) begin
               failNow("unexpected-request");
               waitCnt = 0;
            end else begin
               e = reqQ[0];
               check("req-memWrite", memWrite, e.w);
               check("req-memAddress", memAddress, e.addr);
               check("req-byteEnable", memByteEnable, e.be);
               if (e.w) check("req-writeData", memWriteData, e.wd);
            end
            if (waitCnt == 0) begin
               memReady = 1'b1;
               if (reqQ.size() > 0) void'(reqQ.pop_front());
               lastReqCycles = reqCycles;
               lastBe = memByteEnable;
               reqCycles = 0;
               idx = int'(memAddress >> 2);
               if (memWrite) begin
                  word = dutRead(idx);
                  for (int k = 0; k < 4; k++)
                     if (memByteEnable[k]) word[8*k +: 8] = memWriteData[8*k +: 8];
                  dutMem[idx] = word;
               end else begin
                  respPending = 1'b1;
                  respData = dutRead(idx);
                  respDelay = (respFix >= 0) ? respFix : int'($urandom_range(0, 2));
               end
            end else waitCnt--;
         end
      end
   end

   // Write-back monitor.
   initial begin
      wbExp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            if (alignmentError) errSeen++;
            if (wbValid) begin
               if (wbQ.size() == 0) failNow("unexpected-wb");
               else begin
                  e = wbQ.pop_front();
                  check("wb-addr", wbRegisterWriteAddress, e.wa);
                  check("wb-shouldWrite", wbShouldWriteRegister, e.wsw);
                  if (e.chkData) check("wb-data", wbData, e.data);
               end
            end
         end
      end
   end

   initial begin
      int g;
      logic [1:0] kind, sz;
      logic [31:0] addr;
      reset = 1'b1; exValid = 1'b0; aluOutput = 0; registerRt = 0; registerWriteAddress = 0;
      shouldWriteRegister = 0; shouldReadMemory = 0; shouldWriteMemory = 0;
      memoryAccessSize = 0; shouldSignExtendLoad = 0;
      repeat (2) @(negedge clock);
      checkAllZero("reset");
      reset = 1'b0;

      // ALU op: one edge after capture, no stall
      issue(1, 32'h1234, 32'h0, 5'd5, 1, 0, 0, 2'b10, 0);
      @(negedge clock);
      exValid = 1'b0;
      check("alu-no-stall", memStall, 0);
      @(negedge clock);
      check("alu-wbValid", wbValid, 1);
      check("alu-wbData", wbData, 32'h1234);
      check("alu-wbAddr", wbRegisterWriteAddress, 5);

      // sw held three request cycles
      waitFix = 2;
      issue(1, 32'h100, 32'hDEADBEEF, 5'd9, 0, 0, 1, 2'b10, 0);
      waitWb("sw-wb-timeout");
      check("sw-wbShouldWrite", wbShouldWriteRegister, 0);
      check("sw-request-cycles", lastReqCycles, 3);
      check("sw-byteEnable", lastBe, 4'b1111);
      waitFix = -1;

      // byte/half loads from a known word
      refMem[32'h200 >> 2] = 32'h8001_1234;
      dutMem[32'h200 >> 2] = 32'h8001_1234;
      issue(1, 32'h203, 32'h0, 5'd7, 1, 1, 0, 2'b00, 1);
      waitWb("lb-wb-timeout");
      check("lb-data", wbData, 32'hFFFF_FF80);
      check("lb-byteEnable", lastBe, 4'b1000);
      issue(1, 32'h203, 32'h0, 5'd8, 1, 1, 0, 2'b00, 0);
      waitWb("lbu-wb-timeout");
      check("lbu-data", wbData, 32'h0000_0080);
      issue(1, 32'h202, 32'h0, 5'd9, 1, 1, 0, 2'b01, 1);
      waitWb("lh-wb-timeout");
      check("lh-data", wbData, 32'hFFFF_8001);

      // misaligned half: error pulse, no request, bubble
      issue(1, 32'h201, 32'h0, 5'd10, 1, 1, 0, 2'b01, 1);
      @(negedge clock);
      exValid = 1'b0;
      check("misalign-error", alignmentError, 1);
      check("misalign-no-request", memRequest, 0);
      check("misalign-no-stall", memStall, 0);
      @(negedge clock);
      check("misalign-pulse-end", alignmentError, 0);
      check("misalign-wbValid", wbValid, 0);

      // back-to-back loads, zero-wait memory
      waitFix = 0; respFix = 0;
      issue(1, 32'h100, 32'h0, 5'd11, 1, 1, 0, 2'b10, 0);
      issue(1, 32'h104, 32'h0, 5'd12, 1, 1, 0, 2'b10, 0);
      drain();

      // reset while waiting for a load response
      respFix = 3;
      issue(1, 32'h108, 32'h0, 5'd13, 1, 1, 0, 2'b10, 0);
      g = 0;
      do begin
         @(negedge clock);
         #1;
         exValid = 1'b0;
         g++;
      end while (!memReady && g < 50);
      if (!memReady) failNow("reset-test-accept-timeout");
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkAllZero("midreset");
      wbQ.delete();
      reset = 1'b0;
      repeat (4) begin
         @(negedge clock);
         check("postreset-wbValid", wbValid, 0);
         check("postreset-memRequest", memRequest, 0);
         check("postreset-memStall", memStall, 0);
      end
      respFix = -1; waitFix = -1;

      // randomized mix
      for (int i = 0; i < 80; i++) begin
         kind = 2'($urandom_range(0, 3));
         sz   = 2'($urandom_range(0, 3));
         addr = 32'h100 + 32'($urandom_range(0, 63));
         case (kind)
            2'd0: issue(0, $urandom, $urandom, 5'($urandom), 1, 1, 0, sz, 1);
            2'd1: issue(1, $urandom, $urandom, 5'($urandom), 1'($urandom), 0, 0, sz, 0);
            2'd2: issue(1, addr, $urandom, 5'($urandom), 1'($urandom), 1, 0, sz, 1'($urandom));
            default: issue(1, addr, $urandom, 5'($urandom), 1'($urandom), 0, 1, sz, 0);
         endcase
      end
      drain();

      check("final-wbQ-empty", wbQ.size(), 0);
      check("final-reqQ-empty", reqQ.size(), 0);
      check("alignment-error-count", errSeen, errExp);
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

endmodule
